fetch_stage: RTL and testbench

Instruction-fetch stage and IF/ID pipeline register of the MIPS pipeline. It sits directly upstream of the decode controller and feeds it the 32-bit instruction word. It owns the PC and talks to instruction memory over a req/gnt/rvalid handshake with at most one request outstanding. It absorbs hazard-unit stalls with a 1-entry skid buffer and squashes in-flight fetches on branch/jump redirect.

---
 rtl/fetch_pkg.sv | 13 +
 rtl/fetch_skid_buffer.sv | 55 +++++
 rtl/fetch_stage.sv | 171 +++++++++++++++++
 tb/tb_fetch_stage.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the instruction-fetch stage
package fetch_pkg;

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_WAIT  = 2'd1,
        S_DRAIN = 2'd2
    } fetch_state_e;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/fetch_skid_buffer.sv
// rtl/fetch_skid_buffer.sv - one-entry holding slot for a fetched word while IF/ID is stalled
module fetch_skid_buffer
    import fetch_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        push,
    input  logic        pop,
    input  logic        clear,
    input  logic [31:0] push_instr,
    input  logic [31:0] push_pcplus4,
    output logic        valid,
    output logic [31:0] instr,
    output logic [31:0] pcplus4
);

    logic        valid_q, valid_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pcplus4_q, pcplus4_d;

    // Push wins over pop so a same-cycle refill keeps the new word.
    always_comb begin
        valid_d   = valid_q;
        instr_d   = instr_q;
        pcplus4_d = pcplus4_q;
        if (clear) begin
            valid_d = 1'b0;
            instr_d = NOP_INSTR;
        end else if (push) begin
            valid_d   = 1'b1;
            instr_d   = push_instr;
            pcplus4_d = push_pcplus4;
        end else if (pop) begin
            valid_d = 1'b0;
            instr_d = NOP_INSTR;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q   <= 1'b0;
            instr_q   <= NOP_INSTR;
            pcplus4_q <= 32'h0;
        end else begin
            valid_q   <= valid_d;
            instr_q   <= instr_d;
            pcplus4_q <= pcplus4_d;
        end
    end

    assign valid   = valid_q;
    assign instr   = instr_q;
    assign pcplus4 = pcplus4_q;

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - PC, instruction-memory handshake and IF/ID register; FETCH_STATS_EN adds counters
module fetch_stage
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
`ifdef FETCH_STATS_EN
    , parameter int STAT_W = 32
`endif
) (
    input  logic        Clk,
    input  logic        Rst_n,
    output logic        IMemReq,
    output logic [31:0] IMemAddr,
    input  logic        IMemGnt,
    input  logic        IMemRValid,
    input  logic [31:0] IMemRData,
    input  logic        Stall,
    input  logic        Redirect,
    input  logic [31:0] RedirectPC,
    output logic [31:0] IFID_Instruction,
    output logic [31:0] IFID_PCPlus4,
    output logic        IFID_Valid
`ifdef FETCH_STATS_EN
    , output logic [STAT_W-1:0] FetchCount
    , output logic [STAT_W-1:0] StallCycles
    , output logic [STAT_W-1:0] SquashCount
`endif
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  fetch_pc4_q, fetch_pc4_d;
    logic [31:0]  ifid_instr_q, ifid_instr_d;
    logic [31:0]  ifid_pc4_q, ifid_pc4_d;
    logic         ifid_valid_q, ifid_valid_d;

    logic         skid_valid, skid_push, skid_pop;
    logic [31:0]  skid_instr, skid_pc4;
    logic         rsp_accept, rsp_to_ifid;
    logic         unused_redirect_lsbs;

    assign unused_redirect_lsbs = ^RedirectPC[1:0];

    // A full skid blocks new requests, which is what keeps it from overflowing.
    assign IMemReq  = Rst_n && (state_q == S_FETCH) && !skid_valid && !Redirect;
    assign IMemAddr = pc_q;

    assign rsp_accept  = (state_q == S_WAIT) && IMemRValid && !Redirect;
    assign rsp_to_ifid = rsp_accept && !Stall && !skid_valid;
    assign skid_push   = rsp_accept && !rsp_to_ifid;
    assign skid_pop    = !Redirect && !Stall && skid_valid;

    fetch_skid_buffer u_skid (
        .clk          (Clk),
        .rst_n        (Rst_n),
        .push         (skid_push),
        .pop          (skid_pop),
        .clear        (Redirect),
        .push_instr   (IMemRData),
        .push_pcplus4 (fetch_pc4_q),
        .valid        (skid_valid),
        .instr        (skid_instr),
        .pcplus4      (skid_pc4)
    );

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        fetch_pc4_d  = fetch_pc4_q;
        ifid_instr_d = ifid_instr_q;
        ifid_pc4_d   = ifid_pc4_q;
        ifid_valid_d = ifid_valid_q;
        if (Redirect) begin
            pc_d         = {RedirectPC[31:2], 2'b00};
            ifid_valid_d = 1'b0;
            ifid_instr_d = NOP_INSTR;
            // Any request still in flight belongs to the old path and must be drained.
            case (state_q)
                S_FETCH:         state_d = IMemGnt ? S_DRAIN : S_FETCH;
                S_WAIT, S_DRAIN: state_d = IMemRValid ? S_FETCH : S_DRAIN;
                default:         state_d = S_FETCH;
            endcase
        end else begin
            case (state_q)
                S_FETCH: begin
                    if (!skid_valid && IMemGnt) begin
                        pc_d        = pc_q + 32'd4;
                        fetch_pc4_d = pc_q + 32'd4;
                        state_d     = S_WAIT;
                    end
                end
                S_WAIT, S_DRAIN: begin
                    if (IMemRValid) state_d = S_FETCH;
                end
                default: state_d = S_FETCH;
            endcase
            if (!Stall) begin
                if (skid_valid) begin
                    ifid_instr_d = skid_instr;
                    ifid_pc4_d   = skid_pc4;
                    ifid_valid_d = 1'b1;
                end else if (rsp_to_ifid) begin
                    ifid_instr_d = IMemRData;
                    ifid_pc4_d   = fetch_pc4_q;
                    ifid_valid_d = 1'b1;
                end else begin
                    ifid_instr_d = NOP_INSTR;
                    ifid_valid_d = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q      <= S_FETCH;
            pc_q         <= {RESET_PC[31:2], 2'b00};
            fetch_pc4_q  <= 32'h0;
            ifid_instr_q <= NOP_INSTR;
            ifid_pc4_q   <= 32'h0;
            ifid_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            fetch_pc4_q  <= fetch_pc4_d;
            ifid_instr_q <= ifid_instr_d;
            ifid_pc4_q   <= ifid_pc4_d;
            ifid_valid_q <= ifid_valid_d;
        end
    end

    assign IFID_Instruction = ifid_instr_q;
    assign IFID_PCPlus4     = ifid_pc4_q;
    assign IFID_Valid       = ifid_valid_q;

`ifdef FETCH_STATS_EN
    logic [STAT_W-1:0] fetch_cnt_q, fetch_cnt_d;
    logic [STAT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [STAT_W-1:0] squash_cnt_q, squash_cnt_d;
    logic              squash_evt;

    assign squash_evt = Redirect && (ifid_valid_q || skid_valid || (state_q == S_WAIT)
                                     || ((state_q == S_FETCH) && IMemGnt));

    always_comb begin
        fetch_cnt_d  = fetch_cnt_q;
        stall_cnt_d  = stall_cnt_q;
        squash_cnt_d = squash_cnt_q;
        if (rsp_accept && (fetch_cnt_q != '1))           fetch_cnt_d  = fetch_cnt_q + STAT_W'(1);
        if (Stall && ifid_valid_q && (stall_cnt_q != '1)) stall_cnt_d  = stall_cnt_q + STAT_W'(1);
        if (squash_evt && (squash_cnt_q != '1))          squash_cnt_d = squash_cnt_q + STAT_W'(1);
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            fetch_cnt_q  <= '0;
            stall_cnt_q  <= '0;
            squash_cnt_q <= '0;
        end else begin
            fetch_cnt_q  <= fetch_cnt_d;
            stall_cnt_q  <= stall_cnt_d;
            squash_cnt_q <= squash_cnt_d;
        end
    end

    assign FetchCount  = fetch_cnt_q;
    assign StallCycles = stall_cnt_q;
    assign SquashCount = squash_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - directed bench for fetch_stage with a second instance at a wrapping reset PC
module tb_fetch_stage;

    logic        Clk = 1'b0;
    logic        Rst_n;
    logic        IMemGnt, IMemRValid, Stall, Redirect;
    logic [31:0] IMemRData, RedirectPC;

    logic        IMemReq, IFID_Valid;
    logic [31:0] IMemAddr, IFID_Instruction, IFID_PCPlus4;
    logic        w_IMemReq, w_IFID_Valid;
    logic [31:0] w_IMemAddr, w_IFID_Instruction, w_IFID_PCPlus4;

    int errors = 0;
    int checks = 0;

    always #5 Clk = ~Clk;

    fetch_stage u_dut (
        .Clk(Clk), .Rst_n(Rst_n),
        .IMemReq(IMemReq), .IMemAddr(IMemAddr), .IMemGnt(IMemGnt),
        .IMemRValid(IMemRValid), .IMemRData(IMemRData),
        .Stall(Stall), .Redirect(Redirect), .RedirectPC(RedirectPC),
        .IFID_Instruction(IFID_Instruction), .IFID_PCPlus4(IFID_PCPlus4), .IFID_Valid(IFID_Valid)
    );

    fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) u_dut_wrap (
        .Clk(Clk), .Rst_n(Rst_n),
        .IMemReq(w_IMemReq), .IMemAddr(w_IMemAddr), .IMemGnt(IMemGnt),
        .IMemRValid(IMemRValid), .IMemRData(IMemRData),
        .Stall(Stall), .Redirect(Redirect), .RedirectPC(RedirectPC),
        .IFID_Instruction(w_IFID_Instruction), .IFID_PCPlus4(w_IFID_PCPlus4), .IFID_Valid(w_IFID_Valid)
    );

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic idle();
        IMemGnt = 1'b0; IMemRValid = 1'b0; IMemRData = 32'h0;
        Stall = 1'b0; Redirect = 1'b0; RedirectPC = 32'h0;
    endtask

    task automatic test_reset();
        Rst_n = 1'b0;
        idle();
        tick(); tick();
        checks++; if (IMemReq !== 1'b0) begin errors++; $display("FAIL rst_req got=%0h exp=0", IMemReq); end
        checks++; if (IFID_Valid !== 1'b0) begin errors++; $display("FAIL rst_valid got=%0h exp=0", IFID_Valid); end
        checks++; if (IFID_Instruction !== 32'h0) begin errors++; $display("FAIL rst_instr got=%0h exp=0", IFID_Instruction); end
        checks++; if (IFID_PCPlus4 !== 32'h0) begin errors++; $display("FAIL rst_pc4 got=%0h exp=0", IFID_PCPlus4); end
        Rst_n = 1'b1;
        #1;
        checks++; if (IMemReq !== 1'b1) begin errors++; $display("FAIL rst_first_req got=%0h exp=1", IMemReq); end
        checks++; if (IMemAddr !== 32'h0) begin errors++; $display("FAIL rst_first_addr got=%0h exp=0", IMemAddr); end
    endtask

    task automatic test_basic_fetch();
        IMemGnt = 1'b1;
        tick();
        IMemGnt = 1'b0; IMemRValid = 1'b1; IMemRData = 32'h2008_0005;
        #1;
        checks++; if (IMemReq !== 1'b0) begin errors++; $display("FAIL basic_wait_req got=%0h exp=0", IMemReq); end
        tick();
        idle();
        #1;
        checks++; if (IFID_Instruction !== 32'h2008_0005) begin errors++; $display("FAIL basic_instr got=%0h exp=20080005", IFID_Instruction); end
        checks++; if (IFID_PCPlus4 !== 32'h4) begin errors++; $display("FAIL basic_pc4 got=%0h exp=4", IFID_PCPlus4); end
        checks++; if (IFID_Valid !== 1'b1) begin errors++; $display("FAIL basic_valid got=%0h exp=1", IFID_Valid); end
        checks++; if (IMemReq !== 1'b1 || IMemAddr !== 32'h4) begin errors++; $display("FAIL basic_addr2 got=%0h/%0h exp=1/4", IMemReq, IMemAddr); end
        IMemGnt = 1'b1;
        tick();
        IMemGnt = 1'b0; IMemRValid = 1'b1; IMemRData = 32'h2009_0007;
        checks++; if (IFID_Valid !== 1'b0 || IFID_Instruction !== 32'h0) begin errors++; $display("FAIL basic_bubble got=%0h/%0h exp=0/0", IFID_Valid, IFID_Instruction); end
        tick();
        idle();
        checks++; if (IFID_Instruction !== 32'h2009_0007 || IFID_PCPlus4 !== 32'h8) begin errors++; $display("FAIL b2b_instr got=%0h/%0h exp=20090007/8", IFID_Instruction, IFID_PCPlus4); end
    endtask

    task automatic test_stall_skid();
        IMemGnt = 1'b1; Stall = 1'b1;
        tick();
        IMemGnt = 1'b0; IMemRValid = 1'b1; IMemRData = 32'h0109_4820;
        tick();
        IMemRValid = 1'b0; IMemRData = 32'h0;
        #1;
        checks++; if (IFID_Instruction !== 32'h2009_0007 || IFID_PCPlus4 !== 32'h8 || IFID_Valid !== 1'b1) begin errors++; $display("FAIL stall_hold got=%0h/%0h/%0h exp=20090007/8/1", IFID_Instruction, IFID_PCPlus4, IFID_Valid); end
        checks++; if (IMemReq !== 1'b0) begin errors++; $display("FAIL stall_skid_req got=%0h exp=0", IMemReq); end
        tick();
        Stall = 1'b0;
        #1;
        checks++; if (IMemReq !== 1'b0) begin errors++; $display("FAIL stall_drop_req got=%0h exp=0", IMemReq); end
        tick();
        checks++; if (IFID_Instruction !== 32'h0109_4820 || IFID_PCPlus4 !== 32'hC || IFID_Valid !== 1'b1) begin errors++; $display("FAIL skid_pop got=%0h/%0h/%0h exp=01094820/c/1", IFID_Instruction, IFID_PCPlus4, IFID_Valid); end
        checks++; if (IMemReq !== 1'b1 || IMemAddr !== 32'hC) begin errors++; $display("FAIL skid_resume got=%0h/%0h exp=1/c", IMemReq, IMemAddr); end
    endtask

    task automatic test_redirect_wait();
        IMemGnt = 1'b1;
        tick();
        IMemGnt = 1'b0; Redirect = 1'b1; RedirectPC = 32'h0000_0043;
        #1;
        checks++; if (IMemReq !== 1'b0) begin errors++; $display("FAIL redir_req got=%0h exp=0", IMemReq); end
        tick();
        idle();
        #1;
        checks++; if (IFID_Valid !== 1'b0 || IFID_Instruction !== 32'h0) begin errors++; $display("FAIL redir_squash got=%0h/%0h exp=0/0", IFID_Valid, IFID_Instruction); end
        checks++; if (IMemReq !== 1'b0) begin errors++; $display("FAIL drain_req got=%0h exp=0", IMemReq); end
        tick();
        IMemRValid = 1'b1; IMemRData = 32'hDEAD_BEEF;
        tick();
        idle();
        #1;
        checks++; if (IFID_Valid !== 1'b0 || IFID_Instruction !== 32'h0) begin errors++; $display("FAIL drain_drop got=%0h/%0h exp=0/0", IFID_Valid, IFID_Instruction); end
        checks++; if (IMemReq !== 1'b1 || IMemAddr !== 32'h40) begin errors++; $display("FAIL redir_target got=%0h/%0h exp=1/40", IMemReq, IMemAddr); end
    endtask

    task automatic test_redirect_gnt();
        Redirect = 1'b1; RedirectPC = 32'h0000_0010;
        tick();
        idle();
        #1;
        checks++; if (IMemReq !== 1'b1 || IMemAddr !== 32'h10) begin errors++; $display("FAIL gnt_setup got=%0h/%0h exp=1/10", IMemReq, IMemAddr); end
        IMemGnt = 1'b1; Redirect = 1'b1; RedirectPC = 32'h0000_0080;
        tick();
        idle();
        #1;
        checks++; if (IMemReq !== 1'b0) begin errors++; $display("FAIL gnt_drain_req got=%0h exp=0", IMemReq); end
        IMemRValid = 1'b1; IMemRData = 32'h1234_5678;
        tick();
        idle();
        #1;
        checks++; if (IFID_Valid !== 1'b0 || IFID_Instruction !== 32'h0) begin errors++; $display("FAIL gnt_stale got=%0h/%0h exp=0/0", IFID_Valid, IFID_Instruction); end
        checks++; if (IMemReq !== 1'b1 || IMemAddr !== 32'h80) begin errors++; $display("FAIL gnt_target got=%0h/%0h exp=1/80", IMemReq, IMemAddr); end
        IMemGnt = 1'b1;
        tick();
        IMemGnt = 1'b0; IMemRValid = 1'b1; IMemRData = 32'h8C02_0000;
        tick();
        idle();
        checks++; if (IFID_Instruction !== 32'h8C02_0000 || IFID_PCPlus4 !== 32'h84) begin errors++; $display("FAIL gnt_refetch got=%0h/%0h exp=8c020000/84", IFID_Instruction, IFID_PCPlus4); end
    endtask

    task automatic test_redirect_rvalid();
        IMemGnt = 1'b1;
        tick();
        IMemGnt = 1'b0; IMemRValid = 1'b1; IMemRData = 32'hAAAA_5555;
        Redirect = 1'b1; RedirectPC = 32'h0000_0200;
        tick();
        idle();
        #1;
        checks++; if (IMemReq !== 1'b1 || IMemAddr !== 32'h200) begin errors++; $display("FAIL rv_redir_addr got=%0h/%0h exp=1/200", IMemReq, IMemAddr); end
        checks++; if (IFID_Valid !== 1'b0) begin errors++; $display("FAIL rv_redir_valid got=%0h exp=0", IFID_Valid); end
    endtask

    task automatic test_async_reset();
        IMemGnt = 1'b1;
        tick();
        IMemGnt = 1'b0; IMemRValid = 1'b1; IMemRData = 32'h2402_000A;
        tick();
        idle();
        IMemGnt = 1'b1; Stall = 1'b1;
        tick();
        idle();
        Stall = 1'b1;
        #1;
        checks++; if (IFID_Valid !== 1'b1 || IFID_Instruction !== 32'h2402_000A || IFID_PCPlus4 !== 32'h204) begin errors++; $display("FAIL async_pre got=%0h/%0h/%0h exp=1/2402000a/204", IFID_Valid, IFID_Instruction, IFID_PCPlus4); end
        Rst_n = 1'b0;
        #1;
        checks++; if (IFID_Valid !== 1'b0 || IFID_Instruction !== 32'h0 || IFID_PCPlus4 !== 32'h0) begin errors++; $display("FAIL async_clear got=%0h/%0h/%0h exp=0/0/0", IFID_Valid, IFID_Instruction, IFID_PCPlus4); end
        checks++; if (IMemReq !== 1'b0) begin errors++; $display("FAIL async_req got=%0h exp=0", IMemReq); end
        idle();
        tick();
        Rst_n = 1'b1;
        #1;
        checks++; if (IMemReq !== 1'b1 || IMemAddr !== 32'h0) begin errors++; $display("FAIL async_restart got=%0h/%0h exp=1/0", IMemReq, IMemAddr); end
    endtask

    task automatic test_pc_wrap();
        checks++; if (w_IMemReq !== 1'b1 || w_IMemAddr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_first got=%0h/%0h exp=1/fffffffc", w_IMemReq, w_IMemAddr); end
        IMemGnt = 1'b1;
        tick();
        IMemGnt = 1'b0; IMemRValid = 1'b1; IMemRData = 32'h0000_0001;
        tick();
        idle();
        #1;
        checks++; if (w_IMemReq !== 1'b1 || w_IMemAddr !== 32'h0) begin errors++; $display("FAIL wrap_addr got=%0h/%0h exp=1/0", w_IMemReq, w_IMemAddr); end
        checks++; if (w_IFID_PCPlus4 !== 32'h0 || w_IFID_Valid !== 1'b1) begin errors++; $display("FAIL wrap_pc4 got=%0h/%0h exp=0/1", w_IFID_PCPlus4, w_IFID_Valid); end
        checks++; if (IFID_PCPlus4 !== 32'h4 || IMemAddr !== 32'h4) begin errors++; $display("FAIL wrap_ref got=%0h/%0h exp=4/4", IFID_PCPlus4, IMemAddr); end
    endtask

    initial begin
        test_reset();
        test_basic_fetch();
        test_stall_skid();
        test_redirect_wait();
        test_redirect_gnt();
        test_redirect_rvalid();
        test_async_reset();
        test_pc_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
